// File: rtl/maze_pkg.sv
// maze_pkg: shared constants for the maze game sequencer.
// State/menu/difficulty codes, map geometry and preview lengths.
package maze_pkg;

  localparam int MAP_W = 30;
  localparam int MAP_H = 21;
  localparam int ADDRW = $clog2(MAP_H);
  localparam int XW    = $clog2(MAP_W);

  localparam logic [7:0] START_X = 8'd0;
  localparam logic [7:0] START_Y = 8'd20;
  localparam logic [7:0] GOAL_X  = 8'd29;
  localparam logic [7:0] GOAL_Y  = 8'd0;

  localparam logic [31:0] SHOW_EASY_DFLT = 32'd300_000_000;
  localparam logic [31:0] SHOW_MED_DFLT  = 32'd150_000_000;
  localparam logic [31:0] SHOW_HARD_DFLT = 32'd50_000_000;

  localparam logic [2:0] ST_MENU  = 3'd0;
  localparam logic [2:0] ST_SHOW  = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_LOST  = 3'd4;
  localparam logic [2:0] ST_WON   = 3'd5;

  localparam logic [1:0] SEL_START = 2'd0;
  localparam logic [1:0] SEL_DIFF  = 2'd1;
  localparam logic [1:0] SEL_INSTR = 2'd2;

  localparam logic [1:0] DIFF_EASY = 2'd0;
  localparam logic [1:0] DIFF_MED  = 2'd1;
  localparam logic [1:0] DIFF_HARD = 2'd2;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [1:0] dec3(input logic [1:0] v);
    return (v == 2'd0) ? 2'd2 : v - 2'd1;
  endfunction

endpackage

// File: rtl/preview_timer.sv
// preview_timer: loadable 32-bit down-counter.
// done_o is high while the count sits at zero.
module preview_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        en_i,
  output logic        done_o
);

  logic [31:0] cnt_q;

  assign done_o = (cnt_q == 32'd0);

  // load has priority; otherwise count down and stop at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 32'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && !done_o) begin
      cnt_q <= cnt_q - 32'd1;
    end
  end

endmodule

// File: rtl/maze_game_fsm.sv
// maze_game_fsm: menu, map preview, movement and win/lose sequencer.
// Wall checks read the shared map ROM through a req/gnt port.
module maze_game_fsm
  import maze_pkg::*;
#(
  parameter logic [31:0] SHOW_EASY = SHOW_EASY_DFLT,
  parameter logic [31:0] SHOW_MED  = SHOW_MED_DFLT,
  parameter logic [31:0] SHOW_HARD = SHOW_HARD_DFLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_sel,
  output logic             map_req,
  output logic [ADDRW-1:0] map_addr,
  input  logic             map_gnt,
  input  logic             map_valid,
  input  logic [MAP_W-1:0] map_row,
  output logic [2:0]       state,
  output logic [1:0]       menu_sel,
  output logic [1:0]       difficulty,
  output logic             show_map,
  output logic [7:0]       player_x,
  output logic [7:0]       player_y,
  output logic             lost,
  output logic             won
);

  logic [2:0]  state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  diff_q, diff_d;
  logic [7:0]  px_q, px_d;
  logic [7:0]  py_q, py_d;
  logic [7:0]  cx_q, cx_d;
  logic [7:0]  cy_q, cy_d;
  logic        req_q, req_d;
  logic        show_q, lost_q, won_q;

  logic        mv;
  logic        mv_ok;
  logic [7:0]  nx, ny;
  logic        tmr_load;
  logic        tmr_done;
  logic [31:0] show_len;

  // preview length for the selected difficulty
  always_comb begin
    unique case (diff_q)
      DIFF_MED:  show_len = SHOW_MED;
      DIFF_HARD: show_len = SHOW_HARD;
      default:   show_len = SHOW_EASY;
    endcase
  end

  assign tmr_load = (state_q == ST_MENU) && btn_sel &&
                    (sel_q == SEL_START);

  preview_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (show_len - 32'd1),
    .en_i       (state_q == ST_SHOW),
    .done_o     (tmr_done)
  );

  // pick one direction (up > down > left > right) and bound-check it
  always_comb begin
    mv    = 1'b0;
    mv_ok = 1'b0;
    nx    = px_q;
    ny    = py_q;
    if (btn_up) begin
      mv    = 1'b1;
      mv_ok = (py_q != 8'd0);
      ny    = py_q - 8'd1;
    end else if (btn_down) begin
      mv    = 1'b1;
      mv_ok = (py_q != 8'(MAP_H - 1));
      ny    = py_q + 8'd1;
    end else if (btn_left) begin
      mv    = 1'b1;
      mv_ok = (px_q != 8'd0);
      nx    = px_q - 8'd1;
    end else if (btn_right) begin
      mv    = 1'b1;
      mv_ok = (px_q != 8'(MAP_W - 1));
      nx    = px_q + 8'd1;
    end
  end

  // next-state logic for the game sequencer
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    diff_d  = diff_q;
    px_d    = px_q;
    py_d    = py_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    req_d   = req_q;
    unique case (state_q)
      ST_MENU: begin
        if (btn_sel) begin
          if (sel_q == SEL_START) begin
            state_d = ST_SHOW;
            px_d    = START_X;
            py_d    = START_Y;
          end
        end else if (btn_up) begin
          sel_d = dec3(sel_q);
        end else if (btn_down) begin
          sel_d = inc3(sel_q);
        end else if (btn_left) begin
          if (sel_q == SEL_DIFF) diff_d = dec3(diff_q);
        end else if (btn_right) begin
          if (sel_q == SEL_DIFF) diff_d = inc3(diff_q);
        end
      end
      ST_SHOW: begin
        if (btn_sel || tmr_done) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (mv && mv_ok) begin
          cx_d    = nx;
          cy_d    = ny;
          req_d   = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (req_q) begin
          if (map_gnt) req_d = 1'b0;
        end else if (map_valid) begin
          if (map_row[cx_q[XW-1:0]]) begin
            state_d = ST_LOST;
          end else begin
            px_d = cx_q;
            py_d = cy_q;
            if (cx_q == GOAL_X && cy_q == GOAL_Y) state_d = ST_WON;
            else                                  state_d = ST_PLAY;
          end
        end
      end
      ST_LOST, ST_WON: begin
        if (btn_sel) begin
          state_d = ST_MENU;
          sel_d   = SEL_START;
          px_d    = START_X;
          py_d    = START_Y;
        end
      end
      default: state_d = ST_MENU;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_MENU;
      sel_q   <= SEL_START;
      diff_q  <= DIFF_EASY;
      px_q    <= START_X;
      py_q    <= START_Y;
      cx_q    <= 8'd0;
      cy_q    <= 8'd0;
      req_q   <= 1'b0;
      show_q  <= 1'b0;
      lost_q  <= 1'b0;
      won_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      diff_q  <= diff_d;
      px_q    <= px_d;
      py_q    <= py_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      req_q   <= req_d;
      show_q  <= (state_d == ST_SHOW);
      lost_q  <= (state_d == ST_LOST);
      won_q   <= (state_d == ST_WON);
    end
  end

  assign state      = state_q;
  assign menu_sel   = sel_q;
  assign difficulty = diff_q;
  assign player_x   = px_q;
  assign player_y   = py_q;
  assign map_req    = req_q;
  assign map_addr   = cy_q[ADDRW-1:0];
  assign show_map   = show_q;
  assign lost       = lost_q;
  assign won        = won_q;

endmodule

// File: tb/tb_maze_game_fsm.sv
// tb_maze_game_fsm: directed bench for the maze sequencer.
// A small ROM responder grants requests after a settable delay.
module tb_maze_game_fsm;

  localparam logic [4:0] B_UP = 5'b10000;
  localparam logic [4:0] B_DN = 5'b01000;
  localparam logic [4:0] B_LF = 5'b00100;
  localparam logic [4:0] B_RT = 5'b00010;
  localparam logic [4:0] B_SL = 5'b00001;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic        map_req;
  logic [4:0]  map_addr;
  logic        map_gnt;
  logic        map_valid;
  logic [29:0] map_row;
  logic [2:0]  state;
  logic [1:0]  menu_sel;
  logic [1:0]  difficulty;
  logic        show_map;
  logic [7:0]  player_x, player_y;
  logic        lost, won;

  logic [29:0] rom [0:20];
  logic        rv_auto, rv_man;
  logic [29:0] row_auto;
  logic        rom_en;
  int          gnt_delay;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n;

  assign map_valid = rv_auto | rv_man;
  assign map_row   = rv_man ? 30'h3FFF_FFFF : row_auto;

  always #5 clk = ~clk;

  maze_game_fsm #(.SHOW_HARD(32'd10)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_sel    (btn_sel),
    .map_req    (map_req),
    .map_addr   (map_addr),
    .map_gnt    (map_gnt),
    .map_valid  (map_valid),
    .map_row    (map_row),
    .state      (state),
    .menu_sel   (menu_sel),
    .difficulty (difficulty),
    .show_map   (show_map),
    .player_x   (player_x),
    .player_y   (player_y),
    .lost       (lost),
    .won        (won)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] v);
    {btn_up, btn_down, btn_left, btn_right, btn_sel} = v;
    tick();
    {btn_up, btn_down, btn_left, btn_right, btn_sel} = 5'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && state == 3'd3; i++) tick();
    chk("check_timeout", {31'd0, state == 3'd3}, 32'd0);
  endtask

  task automatic mv(input logic [4:0] v);
    press(v);
    wait_done();
  endtask

  // ROM side: grant after gnt_delay denied cycles, data one cycle later
  initial begin
    int  wcnt;
    logic       pend;
    logic [4:0] paddr;
    wcnt     = 0;
    pend     = 1'b0;
    paddr    = 5'd0;
    map_gnt  = 1'b0;
    rv_auto  = 1'b0;
    row_auto = 30'd0;
    forever begin
      @(posedge clk);
      #1;
      map_gnt = 1'b0;
      rv_auto = 1'b0;
      if (pend) begin
        rv_auto  = 1'b1;
        row_auto = rom[paddr];
        pend     = 1'b0;
      end
      if (map_req && rom_en) begin
        if (wcnt < gnt_delay) begin
          wcnt++;
        end else begin
          map_gnt = 1'b1;
          pend    = 1'b1;
          paddr   = map_addr;
          wcnt    = 0;
        end
      end else if (!map_req) begin
        wcnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    rv_man = 1'b0;
    rom_en = 1'b1;
    gnt_delay = 0;
    {btn_up, btn_down, btn_left, btn_right, btn_sel} = 5'b0;
    for (int i = 0; i < 21; i++) rom[i] = 30'd0;
    repeat (2) tick();
    chk("rst_state", state, 0);
    chk("rst_sel", menu_sel, 0);
    chk("rst_diff", difficulty, 0);
    chk("rst_px", player_x, 0);
    chk("rst_py", player_y, 20);
    chk("rst_req", map_req, 0);
    chk("rst_addr", map_addr, 0);
    chk("rst_show", show_map, 0);
    chk("rst_lost_won", {lost, won}, 0);
    reset = 1'b0;
    tick();

    press(B_UP);        chk("menu_up_wrap", menu_sel, 2);
    press(B_LF);        chk("menu_left_sel", menu_sel, 2);
    chk("menu_left_diff", difficulty, 0);
    press(B_DN);        chk("menu_dn_wrap", menu_sel, 0);
    press(B_DN);        chk("menu_dn_1", menu_sel, 1);
    press(B_DN);        chk("menu_dn_2", menu_sel, 2);
    press(B_DN);        chk("menu_dn_0", menu_sel, 0);
    press(B_DN);        chk("menu_dn_1b", menu_sel, 1);
    press(B_RT);        chk("diff_r1", difficulty, 1);
    press(B_RT);        chk("diff_r2", difficulty, 2);
    press(B_RT);        chk("diff_r_wrap", difficulty, 0);
    press(B_LF);        chk("diff_l_wrap", difficulty, 2);
    press(B_SL);        chk("sel_diff_noop", state, 0);
    press(B_UP | B_DN); chk("menu_prio", menu_sel, 0);

    press(B_SL);
    chk("show_state", state, 1);
    n = 0;
    while (show_map && n < 40) begin
      n++;
      tick();
    end
    chk("show_len", n, 10);
    chk("show_to_play", state, 2);
    chk("spawn_x", player_x, 0);
    chk("spawn_y", player_y, 20);

    press(B_LF);
    chk("left_drop_st", state, 2);
    chk("left_drop_req", map_req, 0);
    press(B_DN);
    chk("down_drop_st", state, 2);
    chk("down_drop_py", player_y, 20);

    rom[18] = 30'h1;
    gnt_delay = 3;
    press(B_UP);
    chk("up_check_st", state, 3);
    chk("up_req", map_req, 1);
    chk("up_addr", map_addr, 19);
    tick();
    chk("denied_req", map_req, 1);
    tick();
    chk("denied_addr", map_addr, 19);
    wait_done();
    chk("up_ok_st", state, 2);
    chk("up_ok_py", player_y, 19);
    chk("up_ok_px", player_x, 0);

    gnt_delay = 0;
    press(B_UP);
    chk("wall_n1_st", state, 3);
    chk("wall_n1_addr", map_addr, 18);
    tick();
    chk("wall_n2_req", map_req, 0);
    chk("wall_n2_st", state, 3);
    tick();
    chk("wall_n3_st", state, 4);
    chk("wall_lost", lost, 1);
    chk("wall_py", player_y, 19);
    press(B_SL);
    chk("lost_menu", state, 0);
    chk("lost_sel", menu_sel, 0);
    chk("lost_py", player_y, 20);
    chk("lost_diff", difficulty, 2);
    chk("lost_clr", lost, 0);

    rom[18] = 30'd0;
    press(B_SL);
    chk("show2", state, 1);
    press(B_SL);
    chk("skip_play", state, 2);
    chk("skip_show", show_map, 0);
    for (int i = 0; i < 15; i++) mv(B_UP);
    chk("walk_py5", player_y, 5);
    press(B_UP | B_RT);
    chk("prio_addr", map_addr, 4);
    wait_done();
    chk("prio_px", player_x, 0);
    chk("prio_py", player_y, 4);
    for (int i = 0; i < 4; i++) mv(B_UP);
    press(B_UP);
    chk("top_drop_st", state, 2);
    chk("top_drop_req", map_req, 0);
    for (int i = 0; i < 28; i++) mv(B_RT);
    chk("pre_goal_px", player_x, 28);
    chk("pre_goal_py", player_y, 0);
    mv(B_RT);
    chk("goal_st", state, 5);
    chk("goal_won", won, 1);
    chk("goal_px", player_x, 29);
    chk("goal_lost", lost, 0);

    press(B_SL);
    chk("won_menu", state, 0);
    press(B_SL);
    press(B_SL);
    chk("play3", state, 2);
    rom_en = 1'b0;
    press(B_UP);
    chk("hold_req", map_req, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_req", map_req, 0);
    chk("async_st", state, 0);
    tick();
    reset = 1'b0;
    rv_man = 1'b1;
    tick();
    rv_man = 1'b0;
    tick();
    chk("late_valid_st", state, 0);
    chk("late_valid_py", player_y, 20);
    chk("late_valid_lost", lost, 0);
    chk("late_valid_req", map_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
